// File: rtl/frac_scan_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for the fractal engine: sweeps an HRES x VRES grid in raster order,
// launches one engine run per pixel and streams iteration counts over valid/ready.
module frac_scan_ctrl #(
    parameter int HRES = 640,
    parameter int VRES = 480,
    parameter int CW   = 32,
    parameter int IW   = 16,
    localparam int XW  = $clog2(HRES),
    localparam int YW  = $clog2(VRES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cx0,
    input  logic [CW-1:0] cy0,
    input  logic [CW-1:0] dx,
    input  logic [CW-1:0] dy,
    input  logic [IW-1:0] max_it_in,
    output logic          eng_start,
    output logic [CW-1:0] eng_cx,
    output logic [CW-1:0] eng_cy,
    output logic [IW-1:0] eng_max_it,
    input  logic          eng_ready,
    input  logic [IW-1:0] eng_iter,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [IW-1:0] pix_iter,
    output logic          busy,
    output logic          done_tick
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cx0_sh, dx_sh, dy_sh;
    logic [IW-1:0] max_it_sh;
    logic          last_pix, end_of_line;

    assign end_of_line = (pix_x == XW'(HRES - 1));
    assign last_pix    = end_of_line && (pix_y == YW'(VRES - 1));
    assign eng_max_it  = max_it_sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Abort overrides everything, including a same-cycle start or handshake.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start)     state_nxt = S_LAUNCH;
                S_LAUNCH: if (eng_ready) state_nxt = S_ARM;
                S_ARM:                   state_nxt = S_WAIT;
                S_WAIT:   if (eng_ready) state_nxt = S_EMIT;
                S_EMIT:   if (pix_ready) state_nxt = last_pix ? S_IDLE : S_LAUNCH;
                default:                 state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        eng_start = (state == S_LAUNCH) && eng_ready && !abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx0_sh    <= '0;
            dx_sh     <= '0;
            dy_sh     <= '0;
            max_it_sh <= '0;
            eng_cx    <= '0;
            eng_cy    <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_iter  <= '0;
            pix_valid <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            if (abort) begin
                pix_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        cx0_sh    <= cx0;
                        dx_sh     <= dx;
                        dy_sh     <= dy;
                        max_it_sh <= max_it_in;
                        eng_cx    <= cx0;
                        eng_cy    <= cy0;
                        pix_x     <= '0;
                        pix_y     <= '0;
                    end
                    S_WAIT: if (eng_ready) begin
                        pix_iter  <= eng_iter;
                        pix_valid <= 1'b1;
                    end
                    // Coordinates advance only on the accepted handshake, so they stay
                    // stable while the downstream writer stalls.
                    S_EMIT: if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last_pix) begin
                            done_tick <= 1'b1;
                        end else if (end_of_line) begin
                            pix_x  <= '0;
                            pix_y  <= pix_y + 1'b1;
                            eng_cx <= cx0_sh;
                            eng_cy <= eng_cy + dy_sh;
                        end else begin
                            pix_x  <= pix_x + 1'b1;
                            eng_cx <= eng_cx + dx_sh;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frac_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for frac_scan_ctrl on a 4x3 grid: fixed-latency engine model, raster-order
// reference built from cx0 + x*dx / cy0 + y*dy, randomized parameters and backpressure.
module tb_frac_scan_ctrl;

    localparam int HRES = 4;
    localparam int VRES = 3;
    localparam int CW   = 32;
    localparam int IW   = 16;
    localparam int XW   = $clog2(HRES);
    localparam int YW   = $clog2(VRES);
    localparam int NPIX = HRES * VRES;
    localparam int PW   = XW + YW + IW;
    localparam int LAT  = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] cx0 = '0, cy0 = '0, dx = '0, dy = '0;
    logic [IW-1:0] max_it_in = '0;
    logic          eng_start;
    logic [CW-1:0] eng_cx, eng_cy;
    logic [IW-1:0] eng_max_it;
    logic          eng_ready = 1'b1;
    logic [IW-1:0] eng_iter = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [IW-1:0] pix_iter;
    logic          busy, done_tick;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;
    logic rdy_force = 1'b1;
    int done_base = 0;

    frac_scan_ctrl #(.HRES(HRES), .VRES(VRES), .CW(CW), .IW(IW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cx0(cx0), .cy0(cy0), .dx(dx), .dy(dy), .max_it_in(max_it_in),
        .eng_start(eng_start), .eng_cx(eng_cx), .eng_cy(eng_cy), .eng_max_it(eng_max_it),
        .eng_ready(eng_ready), .eng_iter(eng_iter),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_iter(pix_iter), .busy(busy), .done_tick(done_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] eng_fn(input logic [CW-1:0] cx, input logic [CW-1:0] cy,
                                             input logic [IW-1:0] mi);
        return cx[31:16] ^ cy[27:12] ^ mi ^ 16'h5A5A;
    endfunction

    // Engine: ready drops the cycle after start and returns LAT cycles later with a result.
    logic [3:0]    eng_cnt = '0;
    logic [CW-1:0] e_cx = '0, e_cy = '0;
    logic [IW-1:0] e_mi = '0;
    always @(posedge clk) begin
        if (eng_start) begin
            eng_ready <= 1'b0;
            eng_cnt   <= 4'(LAT);
            e_cx      <= eng_cx;
            e_cy      <= eng_cy;
            e_mi      <= eng_max_it;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1'b1;
            if (eng_cnt == 1) begin
                eng_ready <= 1'b1;
                eng_iter  <= eng_fn(e_cx, e_cy, e_mi);
            end
        end
    end

    // Downstream acceptance: always, random, or forced by a test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(0, 2) != 0);
                default: pix_ready = rdy_force;
            endcase
        end
    end

    logic [CW-1:0] st_cx[$], st_cy[$];
    logic [IW-1:0] st_mi[$];
    logic [PW-1:0] px_q[$];
    int cyc = 0, done_cnt = 0, bad_start = 0, last_xfer = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (eng_start) begin
            st_cx.push_back(eng_cx);
            st_cy.push_back(eng_cy);
            st_mi.push_back(eng_max_it);
            if (pix_valid || !eng_ready) bad_start <= bad_start + 1;
        end
        if (pix_valid && pix_ready) begin
            px_q.push_back({pix_x, pix_y, pix_iter});
            last_xfer <= cyc;
        end
        if (done_tick) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    logic [CW-1:0] exp_cx[NPIX], exp_cy[NPIX];
    logic [PW-1:0] exp_pix[NPIX];

    task automatic build_exp(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                             input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                             input logic [IW-1:0] m);
        for (int yy = 0; yy < VRES; yy++) begin
            for (int xx = 0; xx < HRES; xx++) begin
                int i;
                i = yy * HRES + xx;
                exp_cx[i]  = c0 + CW'(xx) * d0;
                exp_cy[i]  = c1 + CW'(yy) * d1;
                exp_pix[i] = {XW'(xx), YW'(yy), eng_fn(exp_cx[i], exp_cy[i], m)};
            end
        end
    endtask

    // Called at posedge+1; leaves the frame started and the bench at posedge+1.
    task automatic start_frame(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                               input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                               input logic [IW-1:0] m);
        st_cx.delete(); st_cy.delete(); st_mi.delete(); px_q.delete();
        done_base = done_cnt;
        cx0 = c0; cy0 = c1; dx = d0; dy = d1; max_it_in = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_cnt > done_base) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pix_valid, busy, eng_start, done_tick} !== 4'b0 ||
            {pix_x, pix_y, pix_iter, eng_cx, eng_cy, eng_max_it} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got v=%b b=%b s=%b d=%b x=%h y=%h it=%h cx=%h cy=%h mi=%h exp all 0",
                     pix_valid, busy, eng_start, done_tick, pix_x, pix_y, pix_iter, eng_cx, eng_cy, eng_max_it);
        end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b eng_start=%b exp 0 0", busy, eng_start);
        end
    endtask

    task automatic test_basic;
        bit ok;
        logic [CW-1:0] c0 = 32'hE000_0000, d0 = 32'h0800_0000;
        logic [CW-1:0] c1 = 32'h1000_0000, d1 = 32'hF800_0000;
        logic [IW-1:0] m = 16'd100;
        int bad_mi = 0;
        rdy_mode = 1;
        @(posedge clk); #1;
        build_exp(c0, c1, d0, d1, m);
        start_frame(c0, c1, d0, d1, m);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b exp 1", busy);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got no done_tick exp one"); end
        checks++;
        if (px_q.size() != NPIX || st_cx.size() != NPIX) begin
            errors++;
            $display("FAIL basic_count: got pixels=%0d starts=%0d exp %0d", px_q.size(), st_cx.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (px_q[i] !== exp_pix[i] || st_cx[i] !== exp_cx[i] || st_cy[i] !== exp_cy[i]) begin
                errors++;
                $display("FAIL basic_pix%0d: got pix=%h cx=%h cy=%h exp pix=%h cx=%h cy=%h",
                         i, px_q[i], st_cx[i], st_cy[i], exp_pix[i], exp_cx[i], exp_cy[i]);
            end
            if (st_mi[i] !== m) bad_mi++;
        end
        checks++;
        if (st_cx[3] !== 32'hF800_0000) begin
            errors++; $display("FAIL basic_x3_cx: got %h exp f8000000", st_cx[3]);
        end
        checks++;
        if (st_cx[4] !== 32'hE000_0000) begin
            errors++; $display("FAIL basic_wrap_cx: got %h exp e0000000", st_cx[4]);
        end
        checks++;
        if (st_cy[8] !== 32'h0) begin
            errors++; $display("FAIL basic_row2_cy: got %h exp 0", st_cy[8]);
        end
        checks++;
        if (bad_mi != 0 || eng_max_it !== m) begin
            errors++; $display("FAIL basic_max_it: got bad=%0d mi=%h exp 0 %h", bad_mi, eng_max_it, m);
        end
        repeat (4) @(posedge clk); #1;
        checks++;
        if (done_cnt - done_base != 1 || done_cyc != last_xfer + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got ticks=%0d at=%0d last_xfer=%0d busy=%b exp 1 tick at last_xfer+1 busy 0",
                     done_cnt - done_base, done_cyc, last_xfer, busy);
        end
        rdy_mode = 0;
    endtask

    task automatic test_stall;
        bit ok;
        logic [CW-1:0] c0 = $urandom(), c1 = $urandom(), d0 = $urandom(), d1 = $urandom();
        logic [IW-1:0] m = 16'($urandom_range(1, 65535));
        logic [PW-1:0] snap;
        int n;
        rdy_mode = 2;
        rdy_force = 1'b1;
        @(posedge clk); #1;
        build_exp(c0, c1, d0, d1, m);
        start_frame(c0, c1, d0, d1, m);
        for (int c = 0; c < 300 && st_cx.size() < 2; c++) @(negedge clk);
        rdy_force = 1'b0;
        for (int c = 0; c < 300 && !pix_valid; c++) @(negedge clk);
        snap = {pix_x, pix_y, pix_iter};
        n = st_cx.size();
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== XW'(1) || pix_y !== YW'(0) || pix_iter !== exp_pix[1][IW-1:0]) begin
            errors++;
            $display("FAIL stall_pos: got v=%b x=%0d y=%0d it=%h exp 1 1 0 %h",
                     pix_valid, pix_x, pix_y, pix_iter, exp_pix[1][IW-1:0]);
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (pix_valid !== 1'b1 || {pix_x, pix_y, pix_iter} !== snap || pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b pix=%h rdy=%b exp 1 %h 0",
                         k, pix_valid, {pix_x, pix_y, pix_iter}, pix_ready, snap);
            end
        end
        checks++;
        if (st_cx.size() != n) begin
            errors++; $display("FAIL stall_no_start: got starts=%0d exp %0d", st_cx.size(), n);
        end
        rdy_force = 1'b1;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: got no done_tick exp one"); end
        checks++;
        if (px_q.size() != NPIX || st_cx.size() != NPIX) begin
            errors++;
            $display("FAIL stall_count: got pixels=%0d starts=%0d exp %0d", px_q.size(), st_cx.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (px_q[i] !== exp_pix[i] || st_cx[i] !== exp_cx[i] || st_cy[i] !== exp_cy[i]) begin
                errors++;
                $display("FAIL stall_pix%0d: got pix=%h cx=%h cy=%h exp pix=%h cx=%h cy=%h",
                         i, px_q[i], st_cx[i], st_cy[i], exp_pix[i], exp_cx[i], exp_cy[i]);
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_start_ignored;
        bit ok;
        logic [CW-1:0] c0 = $urandom(), c1 = $urandom(), d0 = $urandom(), d1 = $urandom();
        logic [IW-1:0] m = 16'($urandom());
        int bad_mi = 0;
        rdy_mode = 1;
        @(posedge clk); #1;
        build_exp(c0, c1, d0, d1, m);
        start_frame(c0, c1, d0, d1, m);
        for (int c = 0; c < 500 && st_cx.size() < 5; c++) @(negedge clk);
        @(posedge clk); #1;
        cx0 = c0 ^ 32'h1234_5678; cy0 = ~c1; dx = d0 + 1; dy = d1 - 1; max_it_in = ~m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ignore_timeout: got no done_tick exp one"); end
        checks++;
        if (px_q.size() != NPIX || st_cx.size() != NPIX) begin
            errors++;
            $display("FAIL ignore_count: got pixels=%0d starts=%0d exp %0d", px_q.size(), st_cx.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (px_q[i] !== exp_pix[i] || st_cx[i] !== exp_cx[i] || st_cy[i] !== exp_cy[i]) begin
                errors++;
                $display("FAIL ignore_pix%0d: got pix=%h cx=%h cy=%h exp pix=%h cx=%h cy=%h",
                         i, px_q[i], st_cx[i], st_cy[i], exp_pix[i], exp_cx[i], exp_cy[i]);
            end
            if (st_mi[i] !== m) bad_mi++;
        end
        checks++;
        if (bad_mi != 0) begin errors++; $display("FAIL ignore_max_it: got %0d bad exp 0", bad_mi); end
        rdy_mode = 0;
    endtask

    task automatic test_abort;
        bit ok;
        logic [CW-1:0] c0 = $urandom(), c1 = $urandom(), d0 = $urandom(), d1 = $urandom();
        logic [IW-1:0] m = 16'($urandom());
        int n = 0;
        rdy_mode = 0;
        @(posedge clk); #1;
        start_frame(c0, c1, d0, d1, m);
        // Seventh launch is pixel (2,1); two edges later the controller sits in WAIT.
        for (int c = 0; c < 500 && n < 7; c++) begin
            @(negedge clk);
            if (eng_start) n++;
        end
        @(posedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || px_q.size() != 6) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b pixels=%0d exp 0 0 6", busy, pix_valid, px_q.size());
        end
        checks++;
        if (done_cnt != done_base) begin
            errors++; $display("FAIL abort_no_done: got %0d ticks exp 0", done_cnt - done_base);
        end
        c0 = $urandom(); c1 = $urandom(); d0 = $urandom(); d1 = $urandom(); m = 16'($urandom());
        build_exp(c0, c1, d0, d1, m);
        start_frame(c0, c1, d0, d1, m);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || eng_ready !== 1'b0 || eng_start !== 1'b0) begin
            errors++;
            $display("FAIL abort_withhold: got busy=%b eng_ready=%b eng_start=%b exp 1 0 0", busy, eng_ready, eng_start);
        end
        wait_done(ok);
        checks++;
        if (!ok || done_cnt - done_base != 1) begin
            errors++; $display("FAIL abort_refrm_done: got ok=%b ticks=%0d exp 1 1", ok, done_cnt - done_base);
        end
        checks++;
        if (px_q.size() != NPIX || st_cx.size() != NPIX) begin
            errors++;
            $display("FAIL abort_count: got pixels=%0d starts=%0d exp %0d", px_q.size(), st_cx.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (px_q[i] !== exp_pix[i] || st_cx[i] !== exp_cx[i] || st_cy[i] !== exp_cy[i]) begin
                errors++;
                $display("FAIL abort_pix%0d: got pix=%h cx=%h cy=%h exp pix=%h cx=%h cy=%h",
                         i, px_q[i], st_cx[i], st_cy[i], exp_pix[i], exp_cx[i], exp_cy[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        rdy_mode = 2;
        rdy_force = 1'b0;
        @(posedge clk); #1;
        start_frame($urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom()));
        for (int c = 0; c < 300 && !pix_valid; c++) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pix_valid, busy, eng_start, done_tick} !== 4'b0 ||
            {pix_x, pix_y, pix_iter, eng_cx, eng_cy, eng_max_it} !== '0) begin
            errors++;
            $display("FAIL rstmid_outs: got v=%b b=%b s=%b d=%b x=%h y=%h it=%h cx=%h exp all 0",
                     pix_valid, busy, eng_start, done_tick, pix_x, pix_y, pix_iter, eng_cx);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        rdy_mode = 0;
        n = st_cx.size();
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || st_cx.size() != n) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b starts=%0d exp 0 %0d", busy, st_cx.size(), n);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [CW-1:0] c0 = 32'h7FFF_FFFF, d0 = 32'h7FFF_FFFF, c1 = $urandom(), d1 = $urandom();
        @(posedge clk); #1;
        build_exp(c0, c1, d0, d1, '0);
        start_frame(c0, c1, d0, d1, '0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: got no done_tick exp one"); end
        checks++;
        if (st_cx[1] !== 32'hFFFF_FFFE || st_mi[0] !== '0) begin
            errors++; $display("FAIL wrap_cx1: got cx=%h mi=%h exp fffffffe 0", st_cx[1], st_mi[0]);
        end
        checks++;
        if (px_q.size() != NPIX || st_cx.size() != NPIX) begin
            errors++;
            $display("FAIL wrap_count: got pixels=%0d starts=%0d exp %0d", px_q.size(), st_cx.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (px_q[i] !== exp_pix[i] || st_cx[i] !== exp_cx[i] || st_cy[i] !== exp_cy[i]) begin
                errors++;
                $display("FAIL wrap_pix%0d: got pix=%h cx=%h cy=%h exp pix=%h cx=%h cy=%h",
                         i, px_q[i], st_cx[i], st_cy[i], exp_pix[i], exp_cx[i], exp_cy[i]);
            end
        end
    endtask

    task automatic test_random_frames;
        bit ok;
        logic [CW-1:0] c0, c1, d0, d1;
        logic [IW-1:0] m;
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            c0 = $urandom(); c1 = $urandom(); d0 = $urandom(); d1 = $urandom(); m = 16'($urandom());
            @(posedge clk); #1;
            build_exp(c0, c1, d0, d1, m);
            start_frame(c0, c1, d0, d1, m);
            wait_done(ok);
            checks++;
            if (!ok || px_q.size() != NPIX || st_cx.size() != NPIX) begin
                errors++;
                $display("FAIL rand%0d_count: got ok=%b pixels=%0d starts=%0d exp 1 %0d %0d",
                         f, ok, px_q.size(), st_cx.size(), NPIX, NPIX);
            end
            for (int i = 0; i < NPIX; i++) begin
                checks++;
                if (px_q[i] !== exp_pix[i] || st_cx[i] !== exp_cx[i] || st_cy[i] !== exp_cy[i]) begin
                    errors++;
                    $display("FAIL rand%0d_pix%0d: got pix=%h cx=%h cy=%h exp pix=%h cx=%h cy=%h",
                             f, i, px_q[i], st_cx[i], st_cy[i], exp_pix[i], exp_cx[i], exp_cy[i]);
                end
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_protocol;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bad_start != 0) begin
            errors++;
            $display("FAIL protocol_start: got %0d launches while busy or valid exp 0", bad_start);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion exp finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_start_ignored;
        test_abort;
        test_reset_mid;
        test_wrap;
        test_random_frames;
        test_protocol;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
